// File: rtl/axi_mst128_pkg.sv
// Shared types and constants for the 128-bit single-outstanding AXI initiator.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package axi_mst128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_BRESP = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;

  // Encodings are numerically ordered by severity, so "worst" is a plain max.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mst128.sv
// Command/data stream to single-outstanding AXI INCR bursts of 16-byte beats.
// Latency: address valid 1 cycle after cmd accept; done pulse 1 cycle after final R/B handshake.
// Backpressure: W/R data pass straight through (wr_ready=wready_m1, rready_m1=rd_ready); cmd_ready only in IDLE.
module axi_mst128
  import axi_mst128_pkg::*;
#(
  parameter logic [3:0] AXI_CACHE = 4'b0000,
  parameter logic [2:0] AXI_PROT  = 3'b000
) (
  input  logic          pll_core_cpuclk,
  input  logic          pad_cpu_rst_b,
  // command stream
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [39:0]   cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [7:0]    cmd_id,
  // write-data stream
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [127:0]  wr_data,
  input  logic [15:0]   wr_strb,
  // read-data stream
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [127:0]  rd_data,
  output logic          rd_last,
  // completion
  output logic          done_valid,
  output logic [1:0]    done_resp,
  output logic          done_err,
  // AR channel
  output logic [39:0]   araddr_m1,
  output logic [7:0]    arid_m1,
  output logic [7:0]    arlen_m1,
  output logic [2:0]    arsize_m1,
  output logic [1:0]    arburst_m1,
  output logic [3:0]    arcache_m1,
  output logic [2:0]    arprot_m1,
  output logic          arvalid_m1,
  input  logic          arready_m1,
  // AW channel
  output logic [39:0]   awaddr_m1,
  output logic [7:0]    awid_m1,
  output logic [7:0]    awlen_m1,
  output logic [2:0]    awsize_m1,
  output logic [1:0]    awburst_m1,
  output logic [3:0]    awcache_m1,
  output logic [2:0]    awprot_m1,
  output logic          awvalid_m1,
  input  logic          awready_m1,
  // W channel
  output logic [127:0]  wdata_m1,
  output logic [15:0]   wstrb_m1,
  output logic [7:0]    wid_m1,
  output logic          wlast_m1,
  output logic          wvalid_m1,
  input  logic          wready_m1,
  // R channel
  input  logic [127:0]  rdata_m1,
  input  logic [7:0]    rid_m1,
  input  logic [1:0]    rresp_m1,
  input  logic          rlast_m1,
  input  logic          rvalid_m1,
  output logic          rready_m1,
  // B channel
  input  logic [7:0]    bid_m1,
  input  logic [1:0]    bresp_m1,
  input  logic          bvalid_m1,
  output logic          bready_m1
);

  state_t       r_state;
  state_t       w_next;
  logic [39:0]  r_addr;
  logic [7:0]   r_len;
  logic [7:0]   r_id;
  logic [7:0]   r_beat;
  logic [1:0]   r_resp;
  logic         r_err;
  logic         r_done;

  logic         w_last_beat;
  logic         w_cmd_hs;
  logic         w_r_hs;
  logic         w_w_hs;
  logic         w_b_hs;

  assign w_last_beat = (r_beat == r_len);
  assign w_cmd_hs    = (r_state == ST_IDLE)  && cmd_valid;
  assign w_r_hs      = (r_state == ST_RDATA) && rvalid_m1 && rd_ready;
  assign w_w_hs      = (r_state == ST_WDATA) && wr_valid && wready_m1;
  assign w_b_hs      = (r_state == ST_BRESP) && bvalid_m1;

  // Address channels come from captured registers, so they stay stable while valid is high.
  assign araddr_m1  = r_addr;
  assign arid_m1    = r_id;
  assign arlen_m1   = r_len;
  assign arsize_m1  = SIZE_16B;
  assign arburst_m1 = BURST_INCR;
  assign arcache_m1 = AXI_CACHE;
  assign arprot_m1  = AXI_PROT;
  assign awaddr_m1  = r_addr;
  assign awid_m1    = r_id;
  assign awlen_m1   = r_len;
  assign awsize_m1  = SIZE_16B;
  assign awburst_m1 = BURST_INCR;
  assign awcache_m1 = AXI_CACHE;
  assign awprot_m1  = AXI_PROT;

  // Payloads pass through unconditionally; the valids below decide when they mean anything.
  assign wdata_m1   = wr_data;
  assign wstrb_m1   = wr_strb;
  assign wid_m1     = r_id;
  assign rd_data    = rdata_m1;

  assign done_valid = r_done;
  assign done_resp  = r_resp;
  assign done_err   = r_err;

  // State register; async reset drops every valid/ready immediately via ST_IDLE.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  // Next state and per-state handshake gating; everything is closed outside its own state.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    arvalid_m1 = 1'b0;
    awvalid_m1 = 1'b0;
    wvalid_m1  = 1'b0;
    wr_ready   = 1'b0;
    wlast_m1   = 1'b0;
    rready_m1  = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    bready_m1  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = cmd_write ? ST_WADDR : ST_RADDR;
      end
      ST_RADDR: begin
        arvalid_m1 = 1'b1;
        if (arready_m1) w_next = ST_RDATA;
      end
      ST_RDATA: begin
        rd_valid  = rvalid_m1;
        rready_m1 = rd_ready;
        rd_last   = w_last_beat;
        if (w_r_hs && w_last_beat) w_next = ST_IDLE;
      end
      ST_WADDR: begin
        awvalid_m1 = 1'b1;
        if (awready_m1) w_next = ST_WDATA;
      end
      ST_WDATA: begin
        wvalid_m1 = wr_valid;
        wr_ready  = wready_m1;
        wlast_m1  = w_last_beat;
        if (w_w_hs && w_last_beat) w_next = ST_BRESP;
      end
      ST_BRESP: begin
        bready_m1 = 1'b1;
        if (bvalid_m1) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command capture, beat counting and response/error accumulation for the done report.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_addr <= '0;
      r_len  <= '0;
      r_id   <= '0;
      r_beat <= '0;
      r_resp <= RESP_OKAY;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_r_hs && w_last_beat) || w_b_hs;
      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_id   <= cmd_id;
        r_beat <= '0;
        r_resp <= RESP_OKAY;
        r_err  <= 1'b0;
      end
      if (w_r_hs) begin
        r_resp <= resp_max(r_resp, rresp_m1);
        r_err  <= r_err | (rid_m1 != r_id) | (rlast_m1 != w_last_beat);
      end
      if (w_b_hs) begin
        r_resp <= resp_max(r_resp, bresp_m1);
        r_err  <= r_err | (bid_m1 != r_id);
      end
      // Holding at len keeps len=255 from wrapping to 0 on the final beat.
      if ((w_r_hs || w_w_hs) && !w_last_beat) r_beat <= r_beat + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_mst128.sv
// Directed bench for axi_mst128: bench-side AXI slave, stream driver, hand-computed expectations.
module tb_axi_mst128;

  logic          clk;
  logic          pad_cpu_rst_b;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [39:0]   cmd_addr;
  logic [7:0]    cmd_len, cmd_id;
  logic          wr_valid, wr_ready;
  logic [127:0]  wr_data;
  logic [15:0]   wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [127:0]  rd_data;
  logic          done_valid, done_err;
  logic [1:0]    done_resp;
  logic [39:0]   araddr_m1, awaddr_m1;
  logic [7:0]    arid_m1, arlen_m1, awid_m1, awlen_m1;
  logic [2:0]    arsize_m1, arprot_m1, awsize_m1, awprot_m1;
  logic [1:0]    arburst_m1, awburst_m1;
  logic [3:0]    arcache_m1, awcache_m1;
  logic          arvalid_m1, arready_m1, awvalid_m1, awready_m1;
  logic [127:0]  wdata_m1, rdata_m1;
  logic [15:0]   wstrb_m1;
  logic [7:0]    wid_m1, rid_m1, bid_m1;
  logic          wlast_m1, wvalid_m1, wready_m1;
  logic [1:0]    rresp_m1, bresp_m1;
  logic          rlast_m1, rvalid_m1, rready_m1;
  logic          bvalid_m1, bready_m1;

  int            n_vec;
  int            n_miss;
  logic [1:0]    rresp_tab [0:255];

  axi_mst128 dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(pad_cpu_rst_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .araddr_m1(araddr_m1), .arid_m1(arid_m1), .arlen_m1(arlen_m1), .arsize_m1(arsize_m1),
    .arburst_m1(arburst_m1), .arcache_m1(arcache_m1), .arprot_m1(arprot_m1),
    .arvalid_m1(arvalid_m1), .arready_m1(arready_m1),
    .awaddr_m1(awaddr_m1), .awid_m1(awid_m1), .awlen_m1(awlen_m1), .awsize_m1(awsize_m1),
    .awburst_m1(awburst_m1), .awcache_m1(awcache_m1), .awprot_m1(awprot_m1),
    .awvalid_m1(awvalid_m1), .awready_m1(awready_m1),
    .wdata_m1(wdata_m1), .wstrb_m1(wstrb_m1), .wid_m1(wid_m1), .wlast_m1(wlast_m1),
    .wvalid_m1(wvalid_m1), .wready_m1(wready_m1),
    .rdata_m1(rdata_m1), .rid_m1(rid_m1), .rresp_m1(rresp_m1), .rlast_m1(rlast_m1),
    .rvalid_m1(rvalid_m1), .rready_m1(rready_m1),
    .bid_m1(bid_m1), .bresp_m1(bresp_m1), .bvalid_m1(bvalid_m1), .bready_m1(bready_m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    arready_m1 = 1'b0; awready_m1 = 1'b0; wready_m1 = 1'b0;
    rdata_m1 = '0; rid_m1 = '0; rresp_m1 = '0; rlast_m1 = 1'b0; rvalid_m1 = 1'b0;
    bid_m1 = '0; bresp_m1 = '0; bvalid_m1 = 1'b0;
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 256; i++) rresp_tab[i] = 2'b00;
  endtask

  // Entered and left on a falling edge; the command is accepted at the rising edge in between.
  task automatic send_cmd(input logic wr, input logic [39:0] addr, input logic [7:0] len,
                          input logic [7:0] id);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    #1;
    chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_read(input string nm, input logic [39:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input int bad_rid, input bit drop_last,
                          input bit rnd_rdy, input bit zero_data,
                          input logic [1:0] exp_resp, input logic exp_err);
    int c, c_ar, sk, nhs, bad_stray, bad_pass, bad_last, bad_data;
    bit ar_seen, done_seen;
    logic [1:0] got_resp;
    logic got_err;
    logic [127:0] d;
    c_ar = 0; sk = 0; nhs = 0; bad_stray = 0; bad_pass = 0; bad_last = 0; bad_data = 0;
    ar_seen = 1'b0; done_seen = 1'b0; got_resp = '0; got_err = 1'b0;
    send_cmd(1'b0, addr, len, id);
    chk({nm, "_arvalid_next"}, 128'(arvalid_m1), 128'(1));
    for (c = 0; c < 1200 && !done_seen; c++) begin
      arready_m1 = (c >= 1);
      rd_ready   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      d = zero_data ? '0 : {32'(sk), 32'hA5A5_0000 | 32'(sk), 24'h0, id, 32'h1234_5678 ^ 32'(sk)};
      if (!ar_seen) begin
        // stray response offered before any read is in flight
        rvalid_m1 = 1'b1; rid_m1 = id; rresp_m1 = 2'b00; rlast_m1 = 1'b1; rdata_m1 = d;
      end else if (c >= c_ar + 2 && sk <= int'(len)) begin
        rvalid_m1 = 1'b1; rdata_m1 = d;
        rid_m1    = (sk == bad_rid) ? (id ^ 8'h01) : id;
        rresp_m1  = rresp_tab[sk];
        rlast_m1  = (sk == int'(len)) && !drop_last;
      end else begin
        rvalid_m1 = 1'b0; rlast_m1 = 1'b0;
      end
      #1;
      if (done_valid) begin
        done_seen = 1'b1; got_resp = done_resp; got_err = done_err;
        chk({nm, "_cmd_ready_at_done"}, 128'(cmd_ready), 128'(1));
      end else begin
        if (!ar_seen) begin
          if (rready_m1 !== 1'b0) bad_stray++;
        end else if (c > c_ar) begin
          if (rready_m1 !== rd_ready || rd_valid !== rvalid_m1) bad_pass++;
        end
        if (ar_seen && c > c_ar && rvalid_m1 && rready_m1) begin
          if (rd_data !== d) bad_data++;
          if (rd_last !== (sk == int'(len))) bad_last++;
          nhs++; sk++;
        end
        if (!ar_seen && arvalid_m1 && arready_m1) begin
          ar_seen = 1'b1; c_ar = c;
          chk({nm, "_araddr"}, 128'(araddr_m1), 128'(addr));
          chk({nm, "_arlen_id"}, 128'({arlen_m1, arid_m1}), 128'({len, id}));
          chk({nm, "_arfixed"}, 128'({arsize_m1, arburst_m1, arcache_m1, arprot_m1}),
              128'({3'b100, 2'b01, 4'b0000, 3'b000}));
        end
      end
      @(negedge clk);
    end
    rvalid_m1 = 1'b0; rlast_m1 = 1'b0; rd_ready = 1'b0; arready_m1 = 1'b0;
    #1;
    chk({nm, "_done_seen"}, 128'(done_seen), 128'(1));
    chk({nm, "_handshakes"}, 128'(nhs), 128'(int'(len) + 1));
    chk({nm, "_stray_rready"}, 128'(bad_stray), 128'(0));
    chk({nm, "_r_passthru"}, 128'(bad_pass), 128'(0));
    chk({nm, "_rd_data"}, 128'(bad_data), 128'(0));
    chk({nm, "_rd_last"}, 128'(bad_last), 128'(0));
    chk({nm, "_done_resp"}, 128'(got_resp), 128'(exp_resp));
    chk({nm, "_done_err"}, 128'(got_err), 128'(exp_err));
    chk({nm, "_done_1cyc"}, 128'(done_valid), 128'(0));
    chk({nm, "_resp_held"}, 128'({done_resp, done_err}), 128'({exp_resp, exp_err}));
    @(negedge clk);
  endtask

  task automatic run_write(input string nm, input logic [39:0] addr, input logic [7:0] len,
                           input logic [7:0] id, input bit toggle, input bit rnd_wr,
                           input logic [7:0] bid_v, input logic [1:0] bresp_v,
                           input logic [1:0] exp_resp, input logic exp_err, input int rst_at);
    int c, c_aw, c_wl, nhs, bad_early, bad_pass, bad_b, bad_last, bad_data;
    bit aw_seen, w_all, done_seen;
    logic [1:0] got_resp;
    logic got_err;
    logic [127:0] d;
    logic [15:0] s;
    c_aw = 0; c_wl = 0; nhs = 0; bad_early = 0; bad_pass = 0; bad_b = 0; bad_last = 0; bad_data = 0;
    aw_seen = 1'b0; w_all = 1'b0; done_seen = 1'b0; got_resp = '0; got_err = 1'b0;
    send_cmd(1'b1, addr, len, id);
    chk({nm, "_awvalid_next"}, 128'(awvalid_m1), 128'(1));
    for (c = 0; c < 1200 && !done_seen; c++) begin
      awready_m1 = (c >= 2);
      wr_valid   = toggle ? (c % 2 == 0) : 1'b1;
      d = {32'hFEED_0000 | 32'(nhs), 32'(nhs) * 32'd3, addr[31:0], 24'h0, id};
      s = 16'hFFFF ^ 16'(nhs);
      wr_data = d; wr_strb = s;
      wready_m1 = rnd_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid_m1 = w_all && (c >= c_wl + 2);
      bid_m1 = bid_v; bresp_m1 = bresp_v;
      if (rst_at >= 0 && nhs == rst_at) begin
        pad_cpu_rst_b = 1'b0;
        #1;
        chk({nm, "_rst_valids"}, 128'({arvalid_m1, awvalid_m1, wvalid_m1, rready_m1,
                                        bready_m1, rd_valid, done_valid}), 128'(0));
        chk({nm, "_rst_cmd_ready"}, 128'(cmd_ready), 128'(1));
        @(negedge clk);
        pad_cpu_rst_b = 1'b1;
        set_idle();
        #1;
        chk({nm, "_rst_regs"}, 128'({awaddr_m1, awlen_m1, awid_m1}), 128'(0));
        chk({nm, "_post_rst_ready"}, 128'(cmd_ready), 128'(1));
        @(negedge clk);
        return;
      end
      #1;
      if (done_valid) begin
        done_seen = 1'b1; got_resp = done_resp; got_err = done_err;
      end else begin
        if (!aw_seen && wvalid_m1 !== 1'b0) bad_early++;
        if (!w_all && bready_m1 !== 1'b0) bad_b++;
        if (aw_seen && c > c_aw && !w_all &&
            (wvalid_m1 !== wr_valid || wr_ready !== wready_m1)) bad_pass++;
        if (w_all && c > c_wl && (bready_m1 !== 1'b1 || wvalid_m1 !== 1'b0)) bad_b++;
        if (aw_seen && c > c_aw && !w_all && wvalid_m1 && wready_m1) begin
          if (wdata_m1 !== d || wstrb_m1 !== s || wid_m1 !== id) bad_data++;
          if (wlast_m1 !== (nhs == int'(len))) bad_last++;
          nhs++;
          if (nhs == int'(len) + 1) begin w_all = 1'b1; c_wl = c; end
        end
        if (!aw_seen && awvalid_m1 && awready_m1) begin
          aw_seen = 1'b1; c_aw = c;
          chk({nm, "_awaddr"}, 128'(awaddr_m1), 128'(addr));
          chk({nm, "_awlen_id"}, 128'({awlen_m1, awid_m1}), 128'({len, id}));
          chk({nm, "_awfixed"}, 128'({awsize_m1, awburst_m1, awcache_m1, awprot_m1}),
              128'({3'b100, 2'b01, 4'b0000, 3'b000}));
        end
      end
      @(negedge clk);
    end
    set_idle();
    #1;
    chk({nm, "_done_seen"}, 128'(done_seen), 128'(1));
    chk({nm, "_handshakes"}, 128'(nhs), 128'(int'(len) + 1));
    chk({nm, "_w_before_aw"}, 128'(bad_early), 128'(0));
    chk({nm, "_w_passthru"}, 128'(bad_pass), 128'(0));
    chk({nm, "_bready"}, 128'(bad_b), 128'(0));
    chk({nm, "_w_payload"}, 128'(bad_data), 128'(0));
    chk({nm, "_wlast"}, 128'(bad_last), 128'(0));
    chk({nm, "_done_resp"}, 128'(got_resp), 128'(exp_resp));
    chk({nm, "_done_err"}, 128'(got_err), 128'(exp_err));
    chk({nm, "_done_1cyc"}, 128'(done_valid), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    pad_cpu_rst_b = 1'b0;
    set_idle();
    clear_tab();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("reset_valids", 128'({arvalid_m1, awvalid_m1, wvalid_m1, rready_m1, bready_m1,
                              rd_valid, done_valid}), 128'(0));
    chk("reset_ar_regs", 128'({araddr_m1, arlen_m1, arid_m1}), 128'(0));
    @(negedge clk);
    pad_cpu_rst_b = 1'b1;
    @(negedge clk);

    // Read len 3 from a zero-data slave, rd_ready tied high.
    run_read("rd_basic", 40'h00_0000_1000, 8'd3, 8'h11, -1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);

    // Single-beat write, wr_valid held high, B two cycles after the W beat.
    run_write("wr_len0", 40'h00_0000_2000, 8'd0, 8'h22, 1'b0, 1'b0, 8'h22, 2'b00, 2'b00, 1'b0, -1);

    // Eight-beat write, wr_valid 1010..., random wready, EXOKAY response.
    run_write("wr_len7", 40'h00_0000_3000, 8'd7, 8'h33, 1'b1, 1'b1, 8'h33, 2'b01, 2'b01, 1'b0, -1);

    // SLVERR on the 2nd beat, wrong RID on the 3rd, random rd_ready.
    clear_tab();
    rresp_tab[1] = 2'b10;
    run_read("rd_err", 40'h00_0000_4000, 8'd3, 8'h44, 2, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);

    // Worst response wins over a later milder one.
    clear_tab();
    rresp_tab[0] = 2'b10;
    rresp_tab[1] = 2'b01;
    run_read("rd_max", 40'h01_0000_0010, 8'd2, 8'h55, -1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    clear_tab();

    // DECERR with a mismatching BID.
    run_write("wr_berr", 40'h00_0000_5000, 8'd1, 8'h66, 1'b0, 1'b0, 8'h67, 2'b11, 2'b11, 1'b1, -1);

    // Reset asserted in WDATA with beat 3 pending, then a normal read.
    run_write("wr_rst", 40'h00_0000_6000, 8'd7, 8'h77, 1'b0, 1'b0, 8'h77, 2'b00, 2'b00, 1'b0, 3);
    run_read("rd_after_rst", 40'h00_0000_7000, 8'd1, 8'h78, -1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // Maximum burst, slave omits RLAST on the final beat.
    run_read("rd_len255", 40'h00_0001_0000, 8'd255, 8'h99, -1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
